// File: rtl/forthsuper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : forthsuper_pkg
// Description : Shared state encoding and ASCII constants for the token
//               reader family (atoi_reader, atoi_digit).
// Revision    : 1.0 - initial release
// ============================================================================
package forthsuper_pkg;

    // Controller state encoding, explicit width
    localparam int         c_ST_W     = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_EVAL  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // ASCII reference points used by the decoder and controller
    localparam logic [7:0] c_ASCII_SPACE = 8'h20;
    localparam logic [7:0] c_ASCII_MINUS = 8'h2D;
    localparam logic [7:0] c_ASCII_ZERO  = 8'h30;
    localparam logic [7:0] c_ASCII_UA    = 8'h41;
    localparam logic [7:0] c_ASCII_LA    = 8'h61;

endpackage : forthsuper_pkg
`default_nettype wire

// File: rtl/atoi_digit.sv
`default_nettype none
// ============================================================================
// Module      : atoi_digit
// Description : Combinational byte-to-digit decoder. Decimal digits are
//               always accepted; a-f / A-F only when hex is set.
// Revision    : 1.0 - initial release
// ============================================================================
module atoi_digit
    import forthsuper_pkg::*;
#(
    parameter int MSZ = 8
) (
    input  logic [MSZ-1:0] ch,
    input  logic           hex,
    output logic           valid,
    output logic [3:0]     value
);

    logic w_is_dec;
    logic w_is_lc;
    logic w_is_uc;

    assign w_is_dec = (ch >= MSZ'(c_ASCII_ZERO)) && (ch <= MSZ'(c_ASCII_ZERO + 8'd9));
    assign w_is_lc  = (ch >= MSZ'(c_ASCII_LA))   && (ch <= MSZ'(c_ASCII_LA + 8'd5));
    assign w_is_uc  = (ch >= MSZ'(c_ASCII_UA))   && (ch <= MSZ'(c_ASCII_UA + 8'd5));

    assign valid = w_is_dec | (hex & (w_is_lc | w_is_uc));

    // Low nibble of '0'..'9' is the digit itself; for 'a'/'A' (..1) through
    // 'f'/'F' (..6) adding 9 yields 10..15.
    assign value = w_is_dec ? ch[3:0] : (ch[3:0] + 4'd9);

endmodule : atoi_digit
`default_nettype wire

// File: rtl/atoi_reader.sv
`default_nettype none
// ============================================================================
// Module      : atoi_reader
// Description : Reads a whitespace/NUL-delimited numeric token from byte
//               memory and converts it to a DSZ-bit integer (optional leading
//               '-', two's-complement result, modulo 2^DSZ).
//               Build option ATOI_HEX_EN: when defined, the hex port selects
//               base 16; otherwise the base is fixed at 10.
// Revision    : 1.0 - initial release
// ============================================================================
module atoi_reader
    import forthsuper_pkg::*;
#(
    parameter int MSZ = 8,
    parameter int DSZ = 32,
    parameter int ASZ = 17
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           hex,
    input  logic [ASZ-1:0] tib,
    input  logic [MSZ-1:0] ch,
    output logic [ASZ-1:0] mb_ai,
    output logic           mb_we,
    output logic [MSZ-1:0] mb_vi,
    output logic           bsy,
    output logic [DSZ-1:0] vo,
    output logic           err
);

    logic [c_ST_W-1:0] r_state;
    logic [ASZ-1:0]    r_mb_ai;
    logic [DSZ-1:0]    r_acc;
    logic [DSZ-1:0]    r_vo;
    logic              r_neg;
    logic              r_first;
    logic              r_got_dig;
    logic              r_err;
    logic              r_bsy;

    logic              w_hex;
    logic              w_dig_valid;
    logic [3:0]        w_dig_value;
    logic [DSZ-1:0]    w_dig_ext;
    logic [DSZ-1:0]    w_acc_next;
    logic [DSZ-1:0]    w_result;

`ifdef ATOI_HEX_EN
    assign w_hex = hex;
`else
    logic w_unused_hex;
    assign w_unused_hex = hex;
    assign w_hex        = 1'b0;
`endif

    atoi_digit #(
        .MSZ (MSZ)
    ) u_digit (
        .ch    (ch),
        .hex   (w_hex),
        .valid (w_dig_valid),
        .value (w_dig_value)
    );

    // acc*16 is a nibble shift; acc*10 is acc*8 + acc*2
    assign w_dig_ext  = {{(DSZ-4){1'b0}}, w_dig_value};
    assign w_acc_next = w_hex ? ({r_acc[DSZ-5:0], 4'b0000} + w_dig_ext)
                              : ((r_acc << 3) + (r_acc << 1) + w_dig_ext);
    assign w_result   = r_neg ? (-r_acc) : r_acc;

    assign mb_ai = r_mb_ai;
    assign mb_we = 1'b0;
    assign mb_vi = '0;
    assign bsy   = r_bsy;
    assign vo    = r_vo;
    assign err   = r_err;

    // Conversion controller: one byte per FETCH/EVAL pair, all outputs registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_ST_IDLE;
            r_mb_ai   <= '0;
            r_acc     <= '0;
            r_vo      <= '0;
            r_neg     <= 1'b0;
            r_first   <= 1'b0;
            r_got_dig <= 1'b0;
            r_err     <= 1'b0;
            r_bsy     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (en) begin
                        r_mb_ai   <= tib;
                        r_acc     <= '0;
                        r_neg     <= 1'b0;
                        r_first   <= 1'b1;
                        r_got_dig <= 1'b0;
                        r_err     <= 1'b0;
                        r_bsy     <= 1'b1;
                        r_state   <= c_ST_FETCH;
                    end
                end
                c_ST_FETCH: begin
                    if (!en) begin
                        r_err   <= 1'b1;
                        r_bsy   <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_state <= c_ST_EVAL;
                    end
                end
                c_ST_EVAL: begin
                    if (!en) begin
                        r_err   <= 1'b1;
                        r_bsy   <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else if (w_dig_valid) begin
                        r_acc     <= w_acc_next;
                        r_mb_ai   <= r_mb_ai + ASZ'(1);
                        r_first   <= 1'b0;
                        r_got_dig <= 1'b1;
                        r_state   <= c_ST_FETCH;
                    end else if ((ch == MSZ'(c_ASCII_MINUS)) && r_first) begin
                        r_neg   <= 1'b1;
                        r_first <= 1'b0;
                        r_mb_ai <= r_mb_ai + ASZ'(1);
                        r_state <= c_ST_FETCH;
                    end else if (ch <= MSZ'(c_ASCII_SPACE)) begin
                        // Step past the delimiter so the caller can resume parsing
                        r_mb_ai <= r_mb_ai + ASZ'(1);
                        r_err   <= ~r_got_dig;
                        r_vo    <= w_result;
                        r_bsy   <= 1'b0;
                        r_state <= c_ST_DONE;
                    end else begin
                        // Leave the address on the offending byte for diagnostics
                        r_err   <= 1'b1;
                        r_vo    <= w_result;
                        r_bsy   <= 1'b0;
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (!en) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule : atoi_reader
`default_nettype wire

// File: tb/tb_atoi_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_atoi_reader
// Description : Self-checking bench for atoi_reader: randomized and directed
//               tokens, scoreboard queue, monitor on bsy falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atoi_reader;

    typedef struct {
        logic [31:0] vo;
        logic        err;
        logic [16:0] ai;
        int          cyc;
        bit          chk_ai;
        bit          chk_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        hex;
    logic [16:0] tib;
    logic [7:0]  ch;
    logic [16:0] mb_ai;
    logic        mb_we;
    logic [7:0]  mb_vi;
    logic        bsy;
    logic [31:0] vo;
    logic        err;

    logic [7:0]  mem [0:255];
    logic [7:0]  tok [$];
    exp_t        sb  [$];
    exp_t        last_exp;
    logic [31:0] model_vo;
    int          checks = 0;
    int          errors = 0;
    int          bsy_cnt = 0;
    logic        bsy_prev = 1'b0;

    atoi_reader #(
        .MSZ (8),
        .DSZ (32),
        .ASZ (17)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .hex   (hex),
        .tib   (tib),
        .ch    (ch),
        .mb_ai (mb_ai),
        .mb_we (mb_we),
        .mb_vi (mb_vi),
        .bsy   (bsy),
        .vo    (vo),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after the address
    always @(posedge clk) ch <= mem[mb_ai[7:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int dval(input logic [7:0] c, input bit h);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (h && c >= "a" && c <= "f") return int'(c) - 97 + 10;
        if (h && c >= "A" && c <= "F") return int'(c) - 65 + 10;
        return -1;
    endfunction

    // Reference: walk the token bytes with plain integer arithmetic
    function automatic exp_t model(input logic [16:0] base_addr, input bit h_req);
        exp_t        e;
        logic [31:0] acc = 32'd0;
        bit          neg = 1'b0;
        bit          got = 1'b0;
        bit          h;
        int          d;
`ifdef ATOI_HEX_EN
        h = h_req;
`else
        h = 1'b0;
`endif
        e.chk_ai = 1'b1;
        e.chk_cyc = 1'b1;
        e.err = 1'b1;
        e.ai = base_addr;
        e.cyc = 0;
        for (int i = 0; i < tok.size(); i++) begin
            d = dval(tok[i], h);
            if (d >= 0) begin
                acc = acc * (h ? 32'd16 : 32'd10) + 32'(d);
                got = 1'b1;
            end else if (tok[i] == 8'h2D && i == 0) begin
                neg = 1'b1;
            end else if (tok[i] <= 8'h20) begin
                e.err = !got;
                e.ai = base_addr + 17'(i + 1);
                e.cyc = 2 * (i + 1);
                break;
            end else begin
                e.err = 1'b1;
                e.ai = base_addr + 17'(i);
                e.cyc = 2 * (i + 1);
                break;
            end
        end
        e.vo = neg ? (32'd0 - acc) : acc;
        return e;
    endfunction

    // Monitor: each bsy falling edge ends one transaction
    always @(negedge clk) begin
        exp_t e;
        if (bsy) bsy_cnt++;
        if (bsy_prev && !bsy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion actual=%h required=none", vo);
            end else begin
                e = sb.pop_front();
                chk("vo", vo, e.vo);
                chk("err", {31'd0, err}, {31'd0, e.err});
                if (e.chk_ai)  chk("mb_ai", {15'd0, mb_ai}, {15'd0, e.ai});
                if (e.chk_cyc) chk("bsy_cycles", bsy_cnt, e.cyc);
                chk("mb_we_vi", {23'd0, mb_we, mb_vi}, 32'd0);
            end
            bsy_cnt = 0;
        end
        bsy_prev = bsy;
    end

    task automatic load_str(input logic [7:0] addr, input string s, input logic [7:0] delim);
        tok.delete();
        for (int i = 0; i < s.len(); i++) tok.push_back(s[i]);
        tok.push_back(delim);
        for (int i = 0; i < tok.size(); i++) mem[addr + 8'(i)] = tok[i];
        mem[addr + 8'(tok.size())] = 8'h2E;
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=pending required=complete");
            sb.delete();
        end
    endtask

    // Run the token already in mem/tok, then return to IDLE and check hold
    task automatic run(input logic [7:0] addr, input bit h);
        exp_t e;
        e = model({9'd0, addr}, h);
        sb.push_back(e);
        last_exp = e;
        model_vo = e.vo;
        tib = {9'd0, addr};
        hex = h;
        en = 1'b1;
        @(negedge clk);
        wait_sb();
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_vo", vo, last_exp.vo);
        chk("idle_err", {31'd0, err}, {31'd0, last_exp.err});
        chk("idle_bsy", {31'd0, bsy}, 32'd0);
        if (last_exp.chk_ai) chk("idle_mb_ai", {15'd0, mb_ai}, {15'd0, last_exp.ai});
    endtask

    task automatic rand_tok(input bit h);
        string  hexd = "0123456789abcdefABCDEF";
        string  bad = "x+-.g";
        logic [7:0] c;
        int     n;
        tok.delete();
        if ($urandom_range(0, 3) == 0) tok.push_back(8'h2D);
        n = $urandom_range(0, 10);
        for (int i = 0; i < n; i++) begin
            if (h || $urandom_range(0, 7) == 0) c = hexd[$urandom_range(0, 21)];
            else c = hexd[$urandom_range(0, 9)];
            tok.push_back(c);
        end
        if (tok.size() > 0 && $urandom_range(0, 5) == 0)
            tok[$urandom_range(0, tok.size() - 1)] = bad[$urandom_range(0, 4)];
        case ($urandom_range(0, 2))
            0:       tok.push_back(8'h20);
            1:       tok.push_back(8'h00);
            default: tok.push_back(8'h0A);
        endcase
    endtask

    initial begin
        exp_t e;
        logic [7:0] a;
        bit h;
        for (int i = 0; i < 256; i++) mem[i] = 8'h2E;
        rst = 1'b0; en = 1'b0; hex = 1'b0; tib = '0;
        model_vo = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_vo", vo, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_bsy", {31'd0, bsy}, 32'd0);
        chk("rst_mb_ai", {15'd0, mb_ai}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed tokens with literal expectations
        load_str(8'h10, "123", 8'h20);
        run(8'h10, 1'b0);
        chk("d123_vo", vo, 32'd123);
        chk("d123_ai", {15'd0, mb_ai}, 32'h14);

        load_str(8'h20, "-42", 8'h20);
        run(8'h20, 1'b0);
        chk("dneg42_vo", vo, 32'hFFFFFFD6);

        load_str(8'h30, "1aF", 8'h00);
        run(8'h30, 1'b1);
`ifdef ATOI_HEX_EN
        chk("d1aF_vo", vo, 32'h1AF);
        chk("d1aF_err", {31'd0, err}, 32'd0);
`else
        chk("d1aF_err", {31'd0, err}, 32'd1);
`endif
        run(8'h30, 1'b0);
        chk("d1aF_dec_err", {31'd0, err}, 32'd1);
        chk("d1aF_dec_ai", {15'd0, mb_ai}, 32'h31);

        load_str(8'h40, "4294967297", 8'h20);
        run(8'h40, 1'b0);
        chk("dwrap_vo", vo, 32'd1);
        chk("dwrap_err", {31'd0, err}, 32'd0);

        load_str(8'h60, "", 8'h20);
        run(8'h60, 1'b0);
        chk("dempty_err", {31'd0, err}, 32'd1);
        chk("dempty_vo", vo, 32'd0);

        load_str(8'h68, "-", 8'h20);
        run(8'h68, 1'b0);
        chk("dlone_err", {31'd0, err}, 32'd1);

        // Abort by dropping en mid-token: vo unchanged, err set
        load_str(8'h70, "98765", 8'h20);
        e.vo = model_vo; e.err = 1'b1; e.ai = '0; e.cyc = 0;
        e.chk_ai = 1'b0; e.chk_cyc = 1'b0;
        sb.push_back(e);
        tib = 17'h70; hex = 1'b0; en = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b0;
        wait_sb();
        @(negedge clk);
        chk("abort_idle_err", {31'd0, err}, 32'd1);
        chk("abort_idle_vo", vo, model_vo);

        // Reset during EVAL of the second digit
        load_str(8'h80, "123", 8'h20);
        e.vo = 32'd0; e.err = 1'b0; e.ai = '0; e.cyc = 0;
        e.chk_ai = 1'b1; e.chk_cyc = 1'b0;
        sb.push_back(e);
        tib = 17'h80; en = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wait_sb();
        chk("rst_mid_bsy", {31'd0, bsy}, 32'd0);
        rst = 1'b1; en = 1'b0;
        model_vo = 32'd0;
        @(negedge clk);
        load_str(8'h90, "7", 8'h20);
        run(8'h90, 1'b0);
        chk("after_rst_vo", vo, 32'd7);

        // Randomized tokens against the reference model
        for (int k = 0; k < 60; k++) begin
            h = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 200));
            rand_tok(h);
            for (int i = 0; i < tok.size(); i++) mem[a + 8'(i)] = tok[i];
            mem[a + 8'(tok.size())] = 8'h2E;
            run(a, h);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule : tb_atoi_reader
`default_nettype wire

// File: doc/atoi_reader.md
ATOI_READER -- requirements
Module: atoi_reader

Interface
- REQ-001 Parameter MSZ, default 8: memory byte width.
- REQ-002 Parameter DSZ, default 32: result width.
- REQ-003 Parameter ASZ, default 17: address width.
- REQ-004 clk  input  1  single clock; all logic on posedge clk.
- REQ-005 rst  input  1  reset; synchronous and active-low.
- REQ-006 en  input  1  level enable; a rising level while idle starts a conversion.
- REQ-007 hex  input  1  radix select: 1 = base 16, 0 = base 10.
- REQ-008 tib  input  ASZ  address of the first token byte; sampled at start.
- REQ-009 ch  input  MSZ  memory read data, valid one cycle after mb_ai is driven.
- REQ-010 mb_ai  output  ASZ  memory read address.
- REQ-011 mb_we  output  1  memory write enable; constant 0.
- REQ-012 mb_vi  output  MSZ  memory write data; constant 0.
- REQ-013 bsy  output  1  conversion in progress.
- REQ-014 vo  output  DSZ  converted value.
- REQ-015 err  output  1  token not a valid number.

Function
- REQ-016 States: IDLE, FETCH, EVAL, DONE.
- REQ-017 IDLE with en=1: mb_ai<=tib, acc<=0, neg<=0, first<=1, err<=0, go FETCH; bsy is 1 from the next cycle.
- REQ-018 FETCH: hold mb_ai for one cycle, then go EVAL.
- REQ-019 EVAL samples ch; each byte costs exactly 2 cycles.
- REQ-020 EVAL digit: '0'-'9' always; 'a'-'f'/'A'-'F' only when hex=1. Action: acc<=acc*base+digit (modulo 2^DSZ), mb_ai++, first<=0, go FETCH.
- REQ-021 EVAL '-' with first=1: neg<=1, first<=0, mb_ai++, go FETCH.
- REQ-022 EVAL delimiter (ch<=0x20, includes NUL and space): mb_ai++, go DONE. If no digit has been accepted (empty token or lone '-'), set err=1.
- REQ-023 EVAL any other byte, including '-' not in the first position: err<=1, mb_ai left on the offending byte, go DONE.
- REQ-024 DONE: bsy=0; vo=neg?(-acc mod 2^DSZ):acc; err valid; mb_ai holds the resume address. Stay in DONE while en=1; go IDLE when en=0.
- REQ-025 IDLE: bsy=0; vo, err and mb_ai hold their last values.
- REQ-026 en dropping during FETCH/EVAL aborts the conversion: go IDLE next cycle, vo unchanged, err=1.
- REQ-027 Latency: a token of N bytes plus its delimiter gives bsy=1 for exactly 2*(N+1) cycles.
- REQ-028 hex is sampled in every EVAL cycle; it is required to be stable for the whole conversion.

Reset
- REQ-029 rst=0 at a clock edge forces IDLE, acc=0, vo=0, err=0, mb_ai=0, bsy=0, neg=0; this holds from any state, including mid-conversion.

Configuration
- REQ-030 Macro ATOI_HEX_EN compiled in: the hex port selects the radix as in REQ-020.
- REQ-031 ATOI_HEX_EN absent: the hex port is ignored, base is fixed at 10, and letters take the error path of REQ-023.

Structure
- REQ-032 Shared package forthsuper_pkg holds the state enum and the ASCII constants (SPACE 0x20, '-', '0', 'a', 'A').
- REQ-033 One sub-module atoi_digit: combinational byte-to-digit decoder with inputs ch and hex, outputs valid and value[3:0].

Verification
- REQ-034 Memory at tib=0x10 holds "123 ", hex=0 -> vo=123, err=0, bsy high 8 cycles, final mb_ai=0x14.
- REQ-035 "-42 ", hex=0 -> vo=0xFFFFFFD6, err=0.
- REQ-036 "1aF\0", hex=1 -> vo=0x1AF (431), err=0; same bytes with hex=0 -> err=1, mb_ai on 'a'.
- REQ-037 "4294967297 " -> vo=1 (modulo wrap), err=0; " " alone -> err=1, vo=0.
- REQ-038 rst=0 during the EVAL of the 2nd digit -> next cycle IDLE, bsy=0, vo=0; a new en starts cleanly and converts "7 " to 7.
